// File: rtl/mips_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_pkg
// Description : Shared state encoding and opcode/funct constants for the
//               MIPS bus CPU sequencing controller and datapath helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_cpu_pkg;

  // Controller state; the encoding is visible on the state output.
  typedef enum logic [2:0] {
    S_FETCH      = 3'b000,
    S_DECODE     = 3'b001,
    S_EXECUTE    = 3'b010,
    S_MEM_ACCESS = 3'b011,
    S_WRITE_BACK = 3'b100,
    S_HALTED     = 3'b101
  } state_t;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] c_OP_SPECIAL = 6'b000000;
  localparam logic [5:0] c_OP_REGIMM  = 6'b000001;
  localparam logic [5:0] c_OP_JAL     = 6'b000011;
  localparam logic [5:0] c_OP_LUI     = 6'b001111;
  localparam logic [5:0] c_OP_LB      = 6'b100000;
  localparam logic [5:0] c_OP_LW      = 6'b100011;
  localparam logic [5:0] c_OP_LWR     = 6'b100110;
  localparam logic [5:0] c_OP_SB      = 6'b101000;
  localparam logic [5:0] c_OP_SH      = 6'b101001;
  localparam logic [5:0] c_OP_SWL     = 6'b101010;
  localparam logic [5:0] c_OP_SW      = 6'b101011;
  localparam logic [5:0] c_OP_SWR     = 6'b101110;

  // Upper three opcode bits shared by the ALU-immediate group (ADDI..LUI)
  localparam logic [2:0] c_OP_IMM_GRP = 3'b001;

  // SPECIAL funct codes (IR[5:0]) that do not write a GPR
  localparam logic [5:0] c_FN_JR      = 6'b001000;
  localparam logic [5:0] c_FN_MTHI    = 6'b010001;
  localparam logic [5:0] c_FN_MTLO    = 6'b010011;
  localparam logic [5:0] c_FN_MULT    = 6'b011000;
  localparam logic [5:0] c_FN_DIVU    = 6'b011011;

endpackage
`default_nettype wire

// File: rtl/mips_cpu_instr_class.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_instr_class
// Description : Combinational instruction classifier: opcode/funct to
//               {is_load, is_store, writes_reg}. Also used by the datapath
//               byteenable logic.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_instr_class (
  input  logic [5:0] instr_opcode_i,
  input  logic [5:0] instr_funct_i,
  output logic       is_load_o,
  output logic       is_store_o,
  output logic       writes_reg_o
);
  import mips_cpu_pkg::*;

  // Decode the class bits; REGIMM link writes are handled by the datapath.
  always_comb begin
    is_load_o    = (instr_opcode_i >= c_OP_LB) && (instr_opcode_i <= c_OP_LWR);
    is_store_o   = 1'b0;
    writes_reg_o = is_load_o;

    case (instr_opcode_i)
      c_OP_SB, c_OP_SH, c_OP_SWL, c_OP_SW, c_OP_SWR: is_store_o = 1'b1;
      default: ;
    endcase

    if (instr_opcode_i == c_OP_SPECIAL) begin
      writes_reg_o = !((instr_funct_i == c_FN_JR)   ||
                       (instr_funct_i == c_FN_MTHI) ||
                       (instr_funct_i == c_FN_MTLO) ||
                       ((instr_funct_i >= c_FN_MULT) && (instr_funct_i <= c_FN_DIVU)));
    end else if (instr_opcode_i[5:3] == c_OP_IMM_GRP) begin
      writes_reg_o = 1'b1;
    end else if (instr_opcode_i == c_OP_JAL) begin
      writes_reg_o = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mips_cpu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_ctrl_fsm
// Description : Multicycle sequencing controller for the MIPS bus CPU.
//               FETCH/DECODE/EXECUTE/MEMORY_ACCESS/WRITE_BACK with Avalon
//               read/write strobes, waitrequest stalls, halt on jump to 0
//               and an optional bounded-stall watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_ctrl_fsm #(
  parameter int unsigned MAX_WAIT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       waitrequest,
  input  logic [5:0] instr_opcode,
  input  logic [5:0] instr_funct,
  input  logic       pc_is_zero,
  output logic [2:0] state,
  output logic       active,
  output logic       mem_read,
  output logic       mem_write,
  output logic       addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       stall_timeout
);
  import mips_cpu_pkg::*;

  state_t state_q, state_d;
  logic   active_q, active_d;
  logic   stall_timeout_q, stall_timeout_d;

  logic   w_is_load, w_is_store, w_writes_reg;
  logic   w_mem_read, w_mem_write, w_addr_sel;
  logic   w_ir_write, w_pc_write, w_reg_write;
  logic   w_stall_hit;

  mips_cpu_instr_class u_instr_class (
    .instr_opcode_i (instr_opcode),
    .instr_funct_i  (instr_funct),
    .is_load_o      (w_is_load),
    .is_store_o     (w_is_store),
    .writes_reg_o   (w_writes_reg)
  );

  // The watchdog only exists when a bound is configured. Its stall
  // condition is decoded straight from state/class so it does not feed
  // back through the strobe decode below.
  generate
    if (MAX_WAIT_CYCLES != 0) begin : g_stall_cnt
      localparam int unsigned CNT_W = $clog2(MAX_WAIT_CYCLES + 1);
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             w_strobe_req;
      logic             w_stalled;

      assign w_strobe_req = (state_q == S_FETCH) ||
                            ((state_q == S_MEM_ACCESS) && (w_is_load || w_is_store));
      assign w_stalled    = w_strobe_req && waitrequest;
      assign w_stall_hit  = w_stalled && (cnt_q == CNT_W'(MAX_WAIT_CYCLES - 1));

      // Run length of consecutive stalled strobe cycles.
      always_comb begin
        cnt_d = '0;
        if (w_stalled) cnt_d = cnt_q + CNT_W'(1);
      end

      // Stall run-length register.
      always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end
    end else begin : g_no_stall_cnt
      assign w_stall_hit = 1'b0;
    end
  endgenerate

  // Next-state and Moore output decode (ir_write also looks at waitrequest).
  always_comb begin
    state_d         = state_q;
    active_d        = active_q;
    stall_timeout_d = stall_timeout_q;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_addr_sel      = 1'b0;
    w_ir_write      = 1'b0;
    w_pc_write      = 1'b0;
    w_reg_write     = 1'b0;

    case (state_q)
      S_FETCH: begin
        w_mem_read = 1'b1;
        if (!waitrequest) begin
          w_ir_write = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: state_d = S_MEM_ACCESS;
      S_MEM_ACCESS: begin
        if (w_is_load || w_is_store) begin
          w_mem_read  = w_is_load;
          w_mem_write = w_is_store;
          w_addr_sel  = 1'b1;
          if (!waitrequest) state_d = S_WRITE_BACK;
        end else begin
          state_d = S_WRITE_BACK;
        end
      end
      S_WRITE_BACK: begin
        w_pc_write  = 1'b1;
        w_reg_write = w_writes_reg;
        if (pc_is_zero) begin
          state_d  = S_HALTED;
          active_d = 1'b0;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HALTED: active_d = 1'b0;
      default:  state_d  = S_FETCH;
    endcase

    // A bus that never answers stops the core; the strobe drops once HALTED.
    if (w_stall_hit) begin
      state_d         = S_HALTED;
      active_d        = 1'b0;
      stall_timeout_d = 1'b1;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_FETCH;
      active_q        <= 1'b1;
      stall_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      active_q        <= active_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  // Reset suppresses every strobe so an abandoned instruction has no effect.
  assign state         = state_q;
  assign active        = active_q;
  assign stall_timeout = stall_timeout_q;
  assign mem_read      = w_mem_read  & ~reset;
  assign mem_write     = w_mem_write & ~reset;
  assign addr_sel      = w_addr_sel  & ~reset;
  assign ir_write      = w_ir_write  & ~reset;
  assign pc_write      = w_pc_write  & ~reset;
  assign reg_write     = w_reg_write & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_cpu_ctrl_fsm
// Description : Self-checking bench for mips_cpu_ctrl_fsm: instruction-level
//               trace model, classification table, random instruction mix,
//               halt, mid-instruction reset and stall watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset, reset2, waitrequest, pc_is_zero;
  logic [5:0] opcode, funct;

  logic [2:0] d_state, t_state;
  logic d_active, d_rd, d_wr, d_as, d_irw, d_pcw, d_rgw, d_to;
  logic t_active, t_rd, t_wr, t_as, t_irw, t_pcw, t_rgw, t_to;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       ld;
    logic       st;
    logic       wr;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  mips_cpu_ctrl_fsm #(.MAX_WAIT_CYCLES(0)) dut (
    .clk(clk), .reset(reset), .waitrequest(waitrequest),
    .instr_opcode(opcode), .instr_funct(funct), .pc_is_zero(pc_is_zero),
    .state(d_state), .active(d_active), .mem_read(d_rd), .mem_write(d_wr),
    .addr_sel(d_as), .ir_write(d_irw), .pc_write(d_pcw), .reg_write(d_rgw),
    .stall_timeout(d_to)
  );

  mips_cpu_ctrl_fsm #(.MAX_WAIT_CYCLES(4)) dut_wd (
    .clk(clk), .reset(reset2), .waitrequest(waitrequest),
    .instr_opcode(opcode), .instr_funct(funct), .pc_is_zero(pc_is_zero),
    .state(t_state), .active(t_active), .mem_read(t_rd), .mem_write(t_wr),
    .addr_sel(t_as), .ir_write(t_irw), .pc_write(t_pcw), .reg_write(t_rgw),
    .stall_timeout(t_to)
  );

  // Output vector layout: {state, active, rd, wr, addr_sel, ir_w, pc_w, reg_w, timeout}
  function automatic logic [10:0] ev(input logic [2:0] st, input logic act,
                                     input logic rd, input logic wr, input logic as,
                                     input logic irw, input logic pcw, input logic rgw,
                                     input logic to);
    return {st, act, rd, wr, as, irw, pcw, rgw, to};
  endfunction

  function automatic logic [10:0] got(input bit sel);
    if (sel) return {t_state, t_active, t_rd, t_wr, t_as, t_irw, t_pcw, t_rgw, t_to};
    return {d_state, d_active, d_rd, d_wr, d_as, d_irw, d_pcw, d_rgw, d_to};
  endfunction

  // Instruction classes straight from the opcode/funct ranges.
  function automatic logic [2:0] ref_class(input logic [5:0] op, input logic [5:0] fn);
    int o, f;
    logic ld, st, wr;
    o  = int'(op);
    f  = int'(fn);
    ld = (o >= 32) && (o <= 38);
    st = (o == 40) || (o == 41) || (o == 42) || (o == 43) || (o == 46);
    wr = ld || ((o == 0) && !((f == 8) || (f == 17) || (f == 19) || ((f >= 24) && (f <= 27))))
            || ((o >= 8) && (o <= 15)) || (o == 3);
    return {ld, st, wr};
  endfunction

  // One clock: drive waitrequest, compare mid-cycle, advance past the edge.
  task automatic cyc(input logic w, input logic [10:0] exp, input bit sel, input string tag);
    waitrequest = w;
    @(negedge clk);
    checks++;
    if (got(sel) !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b (st,act,rd,wr,as,irw,pcw,rgw,to)",
               tag, got(sel), exp);
    end
    @(posedge clk);
    #1;
  endtask

  // Expected cycle-by-cycle trace of one instruction, starting in FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic ld, input logic st, input logic wr,
                           input int fw, input int mw, input logic pcz,
                           input bit sel, input string tag);
    for (int i = 0; i < fw; i++) begin
      opcode = 6'($urandom); funct = 6'($urandom); pc_is_zero = 1'($urandom);
      cyc(1'b1, ev(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), sel, {tag, " fetch-wait"});
    end
    opcode = 6'($urandom); funct = 6'($urandom); pc_is_zero = 1'($urandom);
    cyc(1'b0, ev(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), sel, {tag, " fetch"});
    opcode = op; funct = fn;
    cyc(1'($urandom), ev(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), sel, {tag, " decode"});
    pc_is_zero = 1'($urandom);
    cyc(1'($urandom), ev(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), sel, {tag, " execute"});
    if (ld || st) begin
      for (int i = 0; i < mw; i++)
        cyc(1'b1, ev(3'd3, 1'b1, ld, st, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), sel, {tag, " mem-wait"});
      cyc(1'b0, ev(3'd3, 1'b1, ld, st, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), sel, {tag, " mem"});
    end else begin
      cyc(1'($urandom), ev(3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), sel, {tag, " mem-none"});
    end
    pc_is_zero = pcz;
    cyc(1'($urandom), ev(3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, wr, 1'b0), sel, {tag, " writeback"});
    pc_is_zero = 1'b0;
  endtask

  // Absolute time bound for the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Main stimulus.
  initial begin
    logic [5:0] rop, rfn;
    logic [2:0] rc;

    reset = 1'b1; reset2 = 1'b1; waitrequest = 1'b0; pc_is_zero = 1'b0;
    opcode = 6'b0; funct = 6'b0;

    // Classification table {op, funct, load, store, writes_reg}
    tbl.push_back('{6'b001001, 6'b000101, 1'b0, 1'b0, 1'b1}); // ADDIU
    tbl.push_back('{6'b100011, 6'b000000, 1'b1, 1'b0, 1'b1}); // LW
    tbl.push_back('{6'b100000, 6'b000000, 1'b1, 1'b0, 1'b1}); // LB
    tbl.push_back('{6'b100110, 6'b000000, 1'b1, 1'b0, 1'b1}); // LWR
    tbl.push_back('{6'b100111, 6'b000000, 1'b0, 1'b0, 1'b0}); // just past load range
    tbl.push_back('{6'b101011, 6'b000000, 1'b0, 1'b1, 1'b0}); // SW
    tbl.push_back('{6'b101000, 6'b000000, 1'b0, 1'b1, 1'b0}); // SB
    tbl.push_back('{6'b101110, 6'b000000, 1'b0, 1'b1, 1'b0}); // SWR
    tbl.push_back('{6'b101100, 6'b000000, 1'b0, 1'b0, 1'b0}); // not a store
    tbl.push_back('{6'b000000, 6'b100001, 1'b0, 1'b0, 1'b1}); // ADDU
    tbl.push_back('{6'b000000, 6'b001000, 1'b0, 1'b0, 1'b0}); // JR
    tbl.push_back('{6'b000000, 6'b001001, 1'b0, 1'b0, 1'b1}); // JALR
    tbl.push_back('{6'b000000, 6'b010001, 1'b0, 1'b0, 1'b0}); // MTHI
    tbl.push_back('{6'b000000, 6'b010011, 1'b0, 1'b0, 1'b0}); // MTLO
    tbl.push_back('{6'b000000, 6'b010000, 1'b0, 1'b0, 1'b1}); // MFHI
    tbl.push_back('{6'b000000, 6'b011000, 1'b0, 1'b0, 1'b0}); // MULT
    tbl.push_back('{6'b000000, 6'b011011, 1'b0, 1'b0, 1'b0}); // DIVU
    tbl.push_back('{6'b000000, 6'b011100, 1'b0, 1'b0, 1'b1}); // just past DIVU
    tbl.push_back('{6'b001111, 6'b000000, 1'b0, 1'b0, 1'b1}); // LUI
    tbl.push_back('{6'b000011, 6'b000000, 1'b0, 1'b0, 1'b1}); // JAL
    tbl.push_back('{6'b000010, 6'b000000, 1'b0, 1'b0, 1'b0}); // J
    tbl.push_back('{6'b000100, 6'b000000, 1'b0, 1'b0, 1'b0}); // BEQ
    tbl.push_back('{6'b000001, 6'b010000, 1'b0, 1'b0, 1'b0}); // BLTZAL

    @(posedge clk); #1;
    // Reset held: FETCH, active, strobes forced low even with waitrequest=0
    cyc(1'b0, ev(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, "reset-hold");
    reset = 1'b0;

    // ADDIU $2,$0,5 (0x24020005), zero wait
    run_instr(6'b001001, 6'b000101, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, "addiu");
    // LW with 2 fetch waits and 3 memory waits
    run_instr(6'b100011, 6'b000000, 1'b1, 1'b0, 1'b1, 2, 3, 1'b0, 1'b0, "lw-wait");
    // SW zero wait
    run_instr(6'b101011, 6'b000000, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, "sw");

    foreach (tbl[i])
      run_instr(tbl[i].op, tbl[i].fn, tbl[i].ld, tbl[i].st, tbl[i].wr,
                0, int'(i % 2), 1'b0, 1'b0, $sformatf("tbl%0d", i));

    // Random instruction mix, biased towards memory opcodes
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) rop = 6'($urandom_range(32, 47));
      else                           rop = 6'($urandom_range(0, 63));
      rfn = 6'($urandom);
      rc  = ref_class(rop, rfn);
      run_instr(rop, rfn, rc[2], rc[1], rc[0], int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'b0, 1'b0, $sformatf("rand%0d", k));
    end

    // Reset pulsed during EXECUTE of a load
    cyc(1'b0, ev(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0, "rst-mid fetch");
    opcode = 6'b100011; funct = 6'b0;
    cyc(1'b0, ev(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, "rst-mid decode");
    reset = 1'b1;
    cyc(1'b0, ev(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, "rst-mid execute");
    reset = 1'b0;
    run_instr(6'b100011, 6'b0, 1'b1, 1'b0, 1'b1, 1, 0, 1'b0, 1'b0, "after-rst");

    // JR $0 to address 0: final write-back commits, then halted for good
    run_instr(6'b000000, 6'b001000, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, "jr-halt");
    for (int i = 0; i < 21; i++) begin
      pc_is_zero = 1'($urandom);
      cyc(1'($urandom), ev(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0,
          $sformatf("halted%0d", i));
    end
    pc_is_zero = 1'b0;

    // Watchdog instance: waits below the bound never trip it
    reset2 = 1'b0;
    run_instr(6'b100011, 6'b0, 1'b1, 1'b0, 1'b1, 3, 3, 1'b0, 1'b1, "wd-lw");
    // Stuck waitrequest in FETCH: timeout four cycles after FETCH entry
    for (int i = 0; i < 4; i++)
      cyc(1'b1, ev(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1,
          $sformatf("wd-fetch-stall%0d", i));
    for (int i = 0; i < 3; i++)
      cyc(1'b1, ev(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1,
          $sformatf("wd-timeout%0d", i));
    // Reset clears the sticky flag
    reset2 = 1'b1;
    cyc(1'b1, ev(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1, "wd-reset");
    reset2 = 1'b0;
    cyc(1'b0, ev(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1, "wd-refetch");
    // Stuck waitrequest on a load in MEMORY_ACCESS
    opcode = 6'b100000; funct = 6'b0;
    cyc(1'b0, ev(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, "wd-decode");
    cyc(1'b1, ev(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, "wd-execute");
    for (int i = 0; i < 4; i++)
      cyc(1'b1, ev(3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1,
          $sformatf("wd-mem-stall%0d", i));
    cyc(1'b0, ev(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1, "wd-mem-timeout");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_cpu_ctrl_fsm.md
# mips_cpu_ctrl_fsm

Multicycle sequencing controller for the MIPS bus CPU. It steps each instruction through FETCH, DECODE, EXECUTE, MEMORY_ACCESS and WRITE_BACK, and drives the Avalon-style memory strobes. It stalls on `waitrequest` and halts the core when the program jumps to address 0. It sits inside `mips_cpu_bus`, between the instruction register / PC / register file and the external bus.

## Interface
- `MAX_WAIT_CYCLES`, default 0: consecutive `waitrequest` cycles tolerated before a fatal stall; 0 = unbounded, no counter.
- `clk` in 1: single clock, all state on posedge.
- `reset` in 1: synchronous, active-high.
- `waitrequest` in 1: bus stall from memory.
- `instr_opcode` in 6: IR[31:26]; valid from DECODE onward.
- `instr_funct` in 6: IR[5:0]; valid from DECODE onward.
- `pc_is_zero` in 1: datapath next-PC equals 0x00000000; sampled in WRITE_BACK.
- `state` out 3: current state, encoding below.
- `active` out 1: core running.
- `mem_read` out 1: bus read strobe.
- `mem_write` out 1: bus write strobe.
- `addr_sel` out 1: bus address source; 0 = PC, 1 = ALUOut.
- `ir_write` out 1: latch `readdata` into IR.
- `pc_write` out 1: commit next PC.
- `reg_write` out 1: register-file write enable.
- `stall_timeout` out 1: sticky fatal-stall flag.

## Operation
- States: FETCH=000, DECODE=001, EXECUTE=010, MEMORY_ACCESS=011, WRITE_BACK=100, HALTED=101. Codes 110 and 111 go to FETCH.
- Instruction classes, decoded from opcode/funct:
  - load: opcode 100000–100110.
  - store: opcode 101000, 101001, 101010, 101011, 101110.
  - writes_reg: load; opcode 000000 except funct 001000 (JR), 010001, 010011, 011000–011011; opcode 001xxx; 001111; 000011 (JAL); opcode 000001 with rt bit 4 set (BLTZAL/BGEZAL, IR[20] supplied as instr_funct-independent input is not needed: treated as writes_reg=0 in this block, link handled by datapath).
- FETCH:
  - `mem_read`=1, `addr_sel`=0.
  - `waitrequest`=1: stay in FETCH.
  - `waitrequest`=0: `ir_write`=1, go to DECODE.
- DECODE → EXECUTE unconditionally. No strobes.
- EXECUTE → MEMORY_ACCESS unconditionally. No strobes.
- MEMORY_ACCESS:
  - load: `mem_read`=1, `addr_sel`=1.
  - store: `mem_write`=1, `addr_sel`=1.
  - Either: hold the state while `waitrequest`=1.
  - Other instructions: no strobes, leave after 1 cycle.
- WRITE_BACK:
  - `pc_write`=1; `reg_write` = writes_reg.
  - If `pc_is_zero`: go to HALTED. Else go to FETCH.
- HALTED:
  - `active`=0; all strobes 0.
  - Stays in HALTED until `reset`.
- Stall counter, only when `MAX_WAIT_CYCLES`≠0:
  - Counts consecutive cycles with a strobe asserted and `waitrequest`=1; clears on any other cycle.
  - On reaching `MAX_WAIT_CYCLES`: set `stall_timeout`, go to HALTED, drop the strobe that same cycle.
- Outputs are Moore decodes of state plus class; `ir_write` additionally depends on `waitrequest`. `mem_read` and `mem_write` are never both 1.
- Reset values (registered):
  - `state`=FETCH, `active`=1, `stall_timeout`=0, counter=0.
  - While `reset`=1 all strobes and enables are forced to 0.
- Reset mid-instruction: the current instruction is abandoned. No `pc_write` or `reg_write` occurs. FETCH starts on the first cycle after `reset` falls.

## Timing
- Zero-wait instruction: exactly 5 cycles, FETCH to WRITE_BACK.
- Each `waitrequest` cycle in FETCH or in a load/store MEMORY_ACCESS adds 1 cycle.
- `waitrequest` in a non-memory MEMORY_ACCESS, or in DECODE/EXECUTE/WRITE_BACK, is ignored.
- Halt: `active` falls on the posedge that ends the WRITE_BACK where `pc_is_zero`=1. The final instruction's `pc_write` and `reg_write` still occur.
- `stall_timeout` and `active`=0 appear together, `MAX_WAIT_CYCLES` cycles after the first stalled strobe cycle.

## Structure
- Shared package `mips_cpu_pkg` holds:
  - `state_t` enum with the encodings above.
  - Opcode and funct localparams: LW, SW, JR, JAL, SPECIAL, etc.
- Sub-module `mips_cpu_instr_class`: combinational opcode/funct → {is_load, is_store, writes_reg}. It is reused by the datapath's byteenable logic.

## Test plan
- Reset, then ADDIU (0x24020005) with `waitrequest`=0 → state sequence 000,001,010,011,100. `ir_write` high in cycle 1 only; `reg_write`=1 and `pc_write`=1 in cycle 5.
- LW with `waitrequest` high for 2 cycles in FETCH and 3 cycles in MEMORY_ACCESS → 10 cycles total. `mem_read` held during the stalls; `addr_sel`=1 only in MEMORY_ACCESS.
- SW (opcode 101011) → `mem_write`=1 for 1 cycle in MEMORY_ACCESS; `reg_write`=0 throughout; `mem_read`=0 in MEMORY_ACCESS.
- JR $0 with `pc_is_zero`=1 in WRITE_BACK → `pc_write`=1 and `reg_write`=0. `active`=0 and `state`=101 next cycle and stays there for 20 further cycles.
- `MAX_WAIT_CYCLES`=4 with `waitrequest` stuck at 1 in FETCH → `stall_timeout`=1, `active`=0 and `mem_read`=0 four cycles after FETCH entry.
- `reset` pulsed during EXECUTE of a load → no `pc_write`, `reg_write` or `mem_read` in MEMORY_ACCESS. `state`=000, `active`=1 after the reset cycle.
